// File: rtl/ula_operand_seq.sv
// Operand sequencer and result latch in front of the 2-bit ULA: loads A, B, F over three strobes,
// captures the ULA result in EXEC. Define ULA_SEQ_ACC_EN to feed each result back as the next A.
module ula_operand_seq #(
  parameter int unsigned NBITS_OPER   = 2,
  parameter int unsigned NBITS_SELECT = 3,
  parameter int unsigned NBITS_RESULT = 2,
  parameter int unsigned NBITS_COUNT  = 4
) (
  input  logic                    clk_2,
  input  logic                    reset,
  input  logic [NBITS_OPER-1:0]   din,
  input  logic [NBITS_SELECT-1:0] sel_in,
  input  logic                    load,
  input  logic [NBITS_RESULT-1:0] alu_y,
  output logic [NBITS_OPER-1:0]   oper_a,
  output logic [NBITS_OPER-1:0]   oper_b,
  output logic [NBITS_SELECT-1:0] oper_f,
  output logic [NBITS_RESULT-1:0] result,
  output logic                    result_valid,
  output logic [2:0]              state,
  output logic [NBITS_COUNT-1:0]  op_count
);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_F = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    load_q;
  logic                    load_evt;
  logic [NBITS_OPER-1:0]   oper_a_d, oper_b_d;
  logic [NBITS_SELECT-1:0] oper_f_d;
  logic [NBITS_RESULT-1:0] result_d;
  logic                    result_valid_d;
  logic [NBITS_COUNT-1:0]  op_count_d;

  // Strobe history keeps tracking during reset so a held strobe yields no event afterwards.
  always_ff @(posedge clk_2) begin
    load_q <= load;
  end

  assign load_evt = load & ~load_q;

  always_ff @(posedge clk_2) begin
    if (reset) state_q <= LOAD_A;
    else       state_q <= state_d;
  end

  // Next-state and next-register values.
  always_comb begin
    state_d        = state_q;
    oper_a_d       = oper_a;
    oper_b_d       = oper_b;
    oper_f_d       = oper_f;
    result_d       = result;
    result_valid_d = result_valid;
    op_count_d     = op_count;
    case (state_q)
      LOAD_A: begin
        if (load_evt) begin
          oper_a_d = din;
          state_d  = LOAD_B;
        end
      end
      LOAD_B: begin
        if (load_evt) begin
          oper_b_d = din;
          state_d  = LOAD_F;
        end
      end
      LOAD_F: begin
        if (load_evt) begin
          oper_f_d = sel_in;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d       = alu_y;
        result_valid_d = 1'b1;
        op_count_d     = op_count + NBITS_COUNT'(1);
`ifdef ULA_SEQ_ACC_EN
        oper_a_d       = NBITS_OPER'(alu_y);
`endif
        state_d        = SHOW;
      end
      SHOW: begin
        if (load_evt) begin
          result_valid_d = 1'b0;
`ifdef ULA_SEQ_ACC_EN
          state_d        = LOAD_B;
`else
          state_d        = LOAD_A;
`endif
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      oper_a       <= '0;
      oper_b       <= '0;
      oper_f       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      op_count     <= '0;
    end else begin
      oper_a       <= oper_a_d;
      oper_b       <= oper_b_d;
      oper_f       <= oper_f_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      op_count     <= op_count_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ula_operand_seq.sv
// Self-checking bench for ula_operand_seq: directed and random operations against a sequence-level model.
module tb_ula_operand_seq;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] din;
  logic [2:0] sel_in;
  logic       load;
  logic [1:0] alu_y;
  logic [1:0] oper_a, oper_b;
  logic [2:0] oper_f;
  logic [1:0] result;
  logic       result_valid;
  logic [2:0] state;
  logic [3:0] op_count;

  int checks = 0;
  int errors = 0;

`ifdef ULA_SEQ_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  // Model of the sequence as seen from outside
  logic [1:0] m_a, m_res;
  int         m_count;
  bit         m_from_b;

  ula_operand_seq dut (
    .clk_2(clk_2), .reset(reset), .din(din), .sel_in(sel_in), .load(load),
    .alu_y(alu_y), .oper_a(oper_a), .oper_b(oper_b), .oper_f(oper_f),
    .result(result), .result_valid(result_valid), .state(state), .op_count(op_count)
  );

  always #5 clk_2 = ~clk_2;

  function automatic logic [1:0] ula(input logic [1:0] a, input logic [1:0] b, input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 2'd1 : 2'd0;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_y = ula(oper_a, oper_b, oper_f);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising strobe, registered at the next posedge; returns with load released.
  task automatic strobe();
    load = 1'b1;
    @(negedge clk_2);
    load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk_2);
    @(negedge clk_2);
    reset = 1'b0;
    m_a = '0; m_res = '0; m_count = 0; m_from_b = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_a"},     32'(oper_a), 0);
    check({tag, "_b"},     32'(oper_b), 0);
    check({tag, "_f"},     32'(oper_f), 0);
    check({tag, "_res"},   32'(result), 0);
    check({tag, "_valid"}, 32'(result_valid), 0);
    check({tag, "_count"}, 32'(op_count), 0);
  endtask

  task automatic load_ab(input logic [1:0] a, input logic [1:0] b);
    if (!m_from_b) begin
      din = a;
      strobe();
      m_a = a;
      check("a_state", 32'(state), 1);
      check("a_oper", 32'(oper_a), 32'(a));
      @(negedge clk_2);
    end
    din = b;
    strobe();
    check("b_state", 32'(state), 2);
    check("b_oper", 32'(oper_b), 32'(b));
    check("b_oper_a", 32'(oper_a), 32'(m_a));
    @(negedge clk_2);
  endtask

  task automatic finish_op(input logic [1:0] b, input logic [2:0] f);
    logic [1:0] r;
    sel_in = f;
    strobe();
    check("exec_state", 32'(state), 3);
    check("exec_valid", 32'(result_valid), 0);
    check("exec_f", 32'(oper_f), 32'(f));
    @(negedge clk_2);
    r = ula(m_a, b, f);
    m_count = (m_count + 1) % 16;
    m_res = r;
    if (ACC) m_a = r;
    check("show_state", 32'(state), 4);
    check("show_result", 32'(result), 32'(r));
    check("show_valid", 32'(result_valid), 1);
    check("show_count", 32'(op_count), 32'(m_count));
    check("show_oper_a", 32'(oper_a), 32'(m_a));
    check("show_oper_b", 32'(oper_b), 32'(b));
    check("show_oper_f", 32'(oper_f), 32'(f));
    strobe();
    m_from_b = ACC;
    check("exit_state", 32'(state), ACC ? 1 : 0);
    check("exit_valid", 32'(result_valid), 0);
    check("exit_result", 32'(result), 32'(m_res));
    @(negedge clk_2);
  endtask

  task automatic run_op(input logic [1:0] a, input logic [1:0] b, input logic [2:0] f);
    load_ab(a, b);
    finish_op(b, f);
  endtask

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;
    reset = 1'b1; load = 1'b0; din = '0; sel_in = '0;
    m_a = '0; m_res = '0; m_count = 0; m_from_b = 1'b0;
    @(negedge clk_2);
    do_reset();
    check_reset_vals("reset");

    // Basic add, then subtract wrap and compare
    run_op(2'd2, 2'd1, 3'b010);
    if (!ACC) check("add_result", 32'(result), 3);
    run_op(2'd1, 2'd2, 3'b110);
    run_op(2'd1, 2'd2, 3'b111);

    // Strobe held high across reset release yields no event
    reset = 1'b1; load = 1'b1; din = 2'd3;
    @(negedge clk_2); @(negedge clk_2);
    reset = 1'b0;
    m_a = '0; m_res = '0; m_count = 0; m_from_b = 1'b0;
    @(negedge clk_2); @(negedge clk_2);
    check("held_state", 32'(state), 0);
    check("held_oper_a", 32'(oper_a), 0);
    load = 1'b0;
    @(negedge clk_2);
    check("held_rel_state", 32'(state), 0);
    run_op(2'd3, 2'd2, 3'b001);

    // Reset in LOAD_F after A=3, B=3
    load_ab(2'd3, 2'd3);
    do_reset();
    check_reset_vals("midreset");

    // Reset during EXEC discards the capture
    run_op(2'd1, 2'd1, 3'b010);
    load_ab(2'd2, 2'd1);
    sel_in = 3'b010;
    strobe();
    check("rexec_state", 32'(state), 3);
    do_reset();
    check_reset_vals("execreset");

    // Accumulator chain from a fresh reset: 1+1 then +1
    run_op(2'd1, 2'd1, 3'b010);
    check("acc1_result", 32'(result), 2);
    run_op(2'd0, 2'd1, 3'b010);
    if (ACC) check("acc2_result", 32'(result), 3);

    // Random operations through a counter wrap
    do_reset();
    for (int i = 0; i < 18; i++) begin
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ops[$urandom_range(0, 4)]);
    end
    check("wrap_count", 32'(op_count), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
